// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and defaults for the PWM measurement block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int DEFAULT_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_sync_edge.sv
// ============================================================================
// Module      : pwm_sync_edge
// Description : Two-flop synchronizer plus delay flop; emits level, rise, fall.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_pwm,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_pwm;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule : pwm_sync_edge

`default_nettype wire

// File: rtl/pwm_monitor.sv
// ============================================================================
// Module      : pwm_monitor
// Description : Measures PWM period and high time in clk cycles; flags stuck.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_monitor
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
  parameter int TIMEOUT   = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 stuck,
  output logic                 stuck_level
);

  // A TIMEOUT beyond the counter range can never be reached by a saturating count.
  localparam bit                   c_TIMEOUT_REACHABLE = (CNT_WIDTH >= 32) || (TIMEOUT < (1 << CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] c_TIMEOUT_CNT       = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] c_ONE               = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_MAX               = '1;

  logic                 w_level;
  logic                 w_rise;
  logic                 w_fall;
  logic                 w_timeout;
  logic                 w_latch_high;
  logic                 w_meas;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  state_t               w_state_next;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] r_high;
  logic [CNT_WIDTH-1:0] r_period;
  logic [CNT_WIDTH-1:0] r_high_time;
  logic                 r_meas_valid;
  logic                 r_stuck;
  logic                 r_stuck_level;

  pwm_sync_edge u_sync_edge (
    .clk     (clk),
    .reset   (reset),
    .i_pwm   (pwm_in),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_timeout    = c_TIMEOUT_REACHABLE && !w_rise && !w_fall && (r_cnt == c_TIMEOUT_CNT);
  assign w_latch_high = (r_state == HIGH) && w_fall;
  assign w_meas       = (r_state == LOW) && w_rise;

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_rise) begin
      w_cnt_next = c_ONE;
    end else if (r_cnt != c_MAX) begin
      w_cnt_next = r_cnt + c_ONE;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_rise) w_state_next = HIGH;
      HIGH:    if (w_fall) w_state_next = LOW;
      LOW:     if (w_rise) w_state_next = HIGH;
      default: w_state_next = IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_high        <= '0;
      r_period      <= '0;
      r_high_time   <= '0;
      r_meas_valid  <= 1'b0;
      r_stuck       <= 1'b0;
      r_stuck_level <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_meas_valid <= w_meas;
      if (w_latch_high) begin
        r_high <= r_cnt;
      end
      // The count before reload is the full rise-to-rise distance.
      if (w_meas) begin
        r_period    <= r_cnt;
        r_high_time <= r_high;
      end
      if (w_timeout) begin
        r_stuck       <= 1'b1;
        r_stuck_level <= w_level;
      end else if (w_rise || w_fall) begin
        r_stuck <= 1'b0;
      end
    end
  end

  assign period      = r_period;
  assign high_time   = r_high_time;
  assign meas_valid  = r_meas_valid;
  assign stuck       = r_stuck;
  assign stuck_level = r_stuck_level;

endmodule : pwm_monitor

`default_nettype wire

// File: tb/tb_pwm_monitor.sv
// ============================================================================
// Module      : tb_pwm_monitor
// Description : Directed self-checking bench for pwm_monitor (32-bit and 4-bit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_monitor;

  localparam int c_TIMEOUT = 1000;

  logic        clk;
  logic        reset;
  logic        pwm;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        meas_valid;
  logic        stuck;
  logic        stuck_level;
  logic [3:0]  period4;
  logic [3:0]  high_time4;
  logic        meas_valid4;
  logic        stuck4;
  logic        stuck_level4;

  int          total;
  int          bad;
  int          mv_n;
  int          mv_idx;
  logic [31:0] mv_period;
  logic [31:0] mv_high;

  pwm_monitor #(.CNT_WIDTH(32), .TIMEOUT(c_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  pwm_monitor #(.CNT_WIDTH(4), .TIMEOUT(c_TIMEOUT)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .pwm_in      (pwm),
    .period      (period4),
    .high_time   (high_time4),
    .meas_valid  (meas_valid4),
    .stuck       (stuck4),
    .stuck_level (stuck_level4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks holding pwm, accumulating meas_valid pulses into mv_n.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (meas_valid) begin
        mv_n++;
        mv_period = period;
        mv_high   = high_time;
      end
    end
  endtask

  // One PWM cycle: hi clocks high then lo clocks low; step 0 is the first sampling edge.
  task automatic drive_cycle(input int hi, input int lo);
    mv_n   = 0;
    mv_idx = -1;
    for (int i = 0; i < hi + lo; i++) begin
      pwm = (i < hi);
      @(posedge clk);
      #1;
      if (meas_valid) begin
        mv_n++;
        if (mv_idx < 0) mv_idx = i;
        mv_period = period;
        mv_high   = high_time;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mv_n  = 0;
    mv_idx = -1;
    mv_period = '0;
    mv_high   = '0;
    pwm   = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_period", period, 0);
    check("rst_high", high_time, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_stuck", stuck, 0);
    check("rst_stuck_level", stuck_level, 0);
    reset = 1'b0;

    // Held low: stuck rises one edge after the count reaches TIMEOUT.
    mv_n = 0;
    run(c_TIMEOUT);
    check("low_not_yet_stuck", stuck, 0);
    run(1);
    check("low_stuck", stuck, 1);
    check("low_stuck_level", stuck_level, 0);
    check("low_no_valid", mv_n, 0);

    // Rise clears stuck two edges after it is first sampled.
    pwm = 1'b1;
    run(2);
    check("rise_stuck_held", stuck, 1);
    run(1);
    check("rise_stuck_clr", stuck, 0);
    drive_cycle(77, 20);
    check("first_cycle_no_valid", mv_n, 0);

    drive_cycle(80, 20);
    check("pwm80_valid_cnt", mv_n, 1);
    check("pwm80_latency", mv_idx, 2);
    check("pwm80_period", mv_period, 100);
    check("pwm80_high", mv_high, 80);
    check("pwm80_hold_period", period, 100);
    check("pwm80_hold_high", high_time, 80);
    drive_cycle(80, 20);
    check("pwm80b_valid_cnt", mv_n, 1);
    check("pwm80b_period", mv_period, 100);
    check("pwm80b_high", mv_high, 80);

    // Narrow pulses: 1 high, 9 low.
    drive_cycle(1, 9);
    check("narrow0_period", mv_period, 100);
    drive_cycle(1, 9);
    check("narrow1_valid_cnt", mv_n, 1);
    check("narrow1_period", mv_period, 10);
    check("narrow1_high", mv_high, 1);
    drive_cycle(1, 9);
    check("narrow2_period", mv_period, 10);
    check("narrow2_high", mv_high, 1);

    // Held high: stuck with level 1, cleared by the fall.
    pwm  = 1'b1;
    mv_n = 0;
    run(2000);
    check("high_stuck", stuck, 1);
    check("high_stuck_level", stuck_level, 1);
    check("high_one_valid", mv_n, 1);
    pwm = 1'b0;
    run(2);
    check("fall_stuck_held", stuck, 1);
    run(1);
    check("fall_stuck_clr", stuck, 0);
    mv_n = 0;
    run(17);
    check("after_stuck_low_no_valid", mv_n, 0);
    drive_cycle(80, 20);
    check("after_stuck_rise_no_valid", mv_n, 0);
    drive_cycle(80, 20);
    check("after_stuck_valid_cnt", mv_n, 1);
    check("after_stuck_period", mv_period, 100);
    check("after_stuck_high", mv_high, 80);

    // Reset at cycle 50 of a period.
    pwm = 1'b1;
    run(50);
    reset = 1'b1;
    run(1);
    check("midrst_period", period, 0);
    check("midrst_high", high_time, 0);
    check("midrst_valid", meas_valid, 0);
    check("midrst_stuck", stuck, 0);
    check("midrst_stuck_level", stuck_level, 0);
    reset = 1'b0;
    mv_n  = 0;
    run(29);
    pwm = 1'b0;
    run(20);
    check("midrst_no_valid", mv_n, 0);
    drive_cycle(80, 20);
    check("midrst_first_valid_cnt", mv_n, 1);
    drive_cycle(80, 20);
    check("midrst_period_again", mv_period, 100);
    check("midrst_high_again", mv_high, 80);

    // 25-cycle period: the 4-bit instance saturates at 15.
    drive_cycle(5, 20);
    drive_cycle(5, 20);
    check("sat_main_period", mv_period, 25);
    check("sat_main_high", mv_high, 5);
    check("sat4_period", period4, 15);
    check("sat4_high", high_time4, 5);
    check("sat4_stuck", stuck4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pwm_monitor

`default_nettype wire
